dmux_deframer: RTL and testbench
================================

// Module: dmux_deframer
// PURPOSE
//   Time-division demultiplexer: the receive end of a mux-serialised link. A
//   rotating-select mux packs LANES samples per frame onto one W-bit stream;
//   this block captures that stream, routes sample k of each frame to lane k,
//   and presents each complete frame as one parallel word.
//   Sits between the serial link and parallel consumers (register file, ALU).
// PARAMETERS
//   LANES  4  samples (lanes) per frame; >= 2
//   W      1  bits per sample
// PORTS
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous reset, active-low
//   in_data    in   W        serial sample
//   in_sof     in   1        start-of-frame; qualifies in_data as lane 0
//   in_valid   in   1        in_data/in_sof valid
//   in_ready   out  1        block accepts sample this cycle
//   out_data   out  LANES*W  frame; lane k at bits [k*W +: W]
//   out_valid  out  1        out_data holds an unconsumed frame
//   out_ready  in   1        consumer takes frame this cycle
//   err_sync   out  1        one-cycle pulse: framing error detected
// BEHAVIOUR
//   Reset (async assert, sync release): state=HUNT, sel=0, staging=0,
//     out_data=0, out_valid=0, err_sync=0; in_ready=1 (combinational).
//   Accept = in_valid & in_ready; sample accepted at rising edge.
//   States: HUNT (seek frame start), FILL (collecting lanes).
//   HUNT: accept and discard samples with in_sof=0. Accept with in_sof=1 ->
//     staging lane 0 = in_data, sel=1, go FILL.
//   FILL, accept, sel!=0, in_sof=0: staging lane sel = in_data; sel++.
//   FILL, accept, sel!=0, in_sof=1: err_sync=1 next cycle; partial frame
//     dropped; sample taken as new lane 0, sel=1, stay FILL.
//   Last lane (sel==LANES-1, in_sof=0): completed frame (staging + this sample)
//     loads out_data; out_valid=1 next cycle; sel wraps to 0, stay FILL.
//   FILL, accept, sel==0, in_sof=0: err_sync=1 next cycle; sample dropped;
//     go HUNT. FILL, sel==0, in_sof=1: normal lane-0 capture, sel=1.
//   Output handshake: out_valid & out_ready clears out_valid next cycle
//     unless a new frame loads that same cycle (then out_valid stays 1 and
//     out_data updates). out_data stable while out_valid=1 & out_ready=0.
//   in_ready = !(state==FILL & sel==LANES-1 & out_valid & !out_ready);
//     stalls only the last lane while the output is full. Lanes 0..LANES-2
//     of the next frame may fill while a frame waits.
//   Throughput: one frame per LANES cycles, sustained, when out_ready=1.
//   Latency: out_valid high the cycle after the last-lane accept.
//   err_sync: registered; never high two cycles from one error.
//   Reset mid-frame or mid-hold: all state cleared at once; held frame lost.
//   in_data/in_sof ignored when in_valid=0; sel does not advance.
// TESTING  (LANES=4, W=1 unless noted)
//   1 Reset: rst_n=0 mid-frame, out_valid=1 -> out_valid=0, out_data=0,
//     err_sync=0 at once; the next frame needs in_sof.
//   2 Basic: sof+1,0,1,1 on 4 consecutive cycles with out_ready=1 ->
//     out_data=4'b1101, out_valid=1 exactly 1 cycle after the 4th accept.
//   3 Hunt: samples 1,1 (sof=0), then sof+0,1,1,0 -> first two dropped,
//     out_data=4'b0110, err_sync stays 0.
//   4 Resync: sof+1,1, then sof+0,0,0,1 -> err_sync 1 cycle after the 2nd
//     sof; out_data=4'b1000; no frame output for the partial 1,1.
//   5 Backpressure: out_ready=0, send 2 full frames -> frame 1 held stable;
//     in_ready=0 only at lane 3 of frame 2; out_ready=1 -> frame 1 taken,
//     then frame 2 loads with no gap or loss.
//   6 Missing sof: after a full frame send 0 (sof=0) at lane 0 -> err_sync
//     pulse, HUNT; following sof+frame decodes correctly. W=8: lanes
//     8'hA5,8'h3C,8'hFF,8'h00 -> out_data=32'h00FF3CA5.

Source files
------------

// File: rtl/dmux_deframer_if.sv
// Serial-in / frame-out stream bundle for the TDM deframer.
// The slave side is the deframer; the master side is the link source plus frame consumer.
interface dmux_deframer_if #(
    parameter int LANES = 4,
    parameter int W     = 1
);
    logic [W-1:0]       in_data;
    logic               in_sof;
    logic               in_valid;
    logic               in_ready;
    logic [LANES*W-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               err_sync;

    modport master (
        output in_data, in_sof, in_valid, out_ready,
        input  in_ready, out_data, out_valid, err_sync
    );

    modport slave (
        input  in_data, in_sof, in_valid, out_ready,
        output in_ready, out_data, out_valid, err_sync
    );
endinterface

// File: rtl/dmux_deframer.sv
// TDM deframer: routes sample k of each start-of-frame aligned group to lane k
// and presents each completed frame as one parallel word with a valid/ready handshake.
module dmux_deframer #(
    parameter int LANES = 4,
    parameter int W     = 1
) (
    input logic          clk,
    input logic          rst_n,
    dmux_deframer_if.slave bus
);
    localparam int SEL_W = (LANES > 2) ? $clog2(LANES) : 1;
    localparam int LAST_I = LANES - 1;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);

    typedef enum logic {HUNT, FILL} state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel;
    logic [LANES*W-1:0] staging;
    logic [LANES*W-1:0] frame;
    logic [LANES*W-1:0] out_data_q;
    logic               out_valid_q;
    logic               err_q;
    logic               accept;

    // Only the last lane stalls: it is the sample that would overwrite a held frame.
    assign bus.in_ready  = !(state == FILL && sel == LAST && out_valid_q && !bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err_sync  = err_q;

    always_comb begin
        frame = staging;
        frame[LAST_I*W +: W] = bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            sel         <= '0;
            staging     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (out_valid_q && bus.out_ready)
                out_valid_q <= 1'b0;
            if (accept) begin
                case (state)
                    HUNT: begin
                        if (bus.in_sof) begin
                            staging[W-1:0] <= bus.in_data;
                            sel            <= SEL_W'(1);
                            state          <= FILL;
                        end
                    end
                    FILL: begin
                        if (bus.in_sof) begin
                            // A start-of-frame anywhere but lane 0 abandons the partial frame.
                            if (sel != '0)
                                err_q <= 1'b1;
                            staging[W-1:0] <= bus.in_data;
                            sel            <= SEL_W'(1);
                        end else if (sel == '0) begin
                            err_q <= 1'b1;
                            state <= HUNT;
                        end else if (sel == LAST) begin
                            out_data_q  <= frame;
                            out_valid_q <= 1'b1;
                            sel         <= '0;
                        end else begin
                            staging[sel*W +: W] <= bus.in_data;
                            sel                 <= sel + SEL_W'(1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dmux_deframer.sv
// Scoreboard bench for dmux_deframer: directed frames push expected words, monitors pop on handshake.
module tb_dmux_deframer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmux_deframer_if #(.LANES(4), .W(1)) b4 ();
    dmux_deframer_if #(.LANES(4), .W(8)) b8 ();

    dmux_deframer #(.LANES(4), .W(1)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    dmux_deframer #(.LANES(4), .W(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

    int n_cmp = 0;
    int n_bad = 0;
    int errs4 = 0;
    int errs8 = 0;
    logic [3:0]  q4[$];
    logic [31:0] q8[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame monitors: compare whenever a frame is handed over.
    always @(negedge clk) begin
        if (rst_n && b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL frame4: got %0h expected none at %0t", b4.out_data, $time);
            end else chk("frame4", 32'(b4.out_data), 32'(q4.pop_front()));
        end
        if (rst_n && b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL frame8: got %0h expected none at %0t", b8.out_data, $time);
            end else chk("frame8", b8.out_data, q8.pop_front());
        end
        if (rst_n && b4.err_sync) errs4++;
        if (rst_n && b8.err_sync) errs8++;
    end

    task automatic send4(input logic sof, input logic d);
        bit done = 0;
        b4.in_valid = 1'b1; b4.in_sof = sof; b4.in_data = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = b4.in_ready;
            @(posedge clk); #1;
        end
        if (!done) chk("send4_timeout", 32'd0, 32'd1);
    endtask

    task automatic send8(input logic sof, input logic [7:0] d);
        bit done = 0;
        b8.in_valid = 1'b1; b8.in_sof = sof; b8.in_data = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = b8.in_ready;
            @(posedge clk); #1;
        end
        if (!done) chk("send8_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        b4.in_valid = 1'b0; b8.in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        b4.in_valid = 0; b4.in_sof = 0; b4.in_data = '0; b4.out_ready = 1;
        b8.in_valid = 0; b8.in_sof = 0; b8.in_data = '0; b8.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
        chk("rst_out_data",  32'(b4.out_data),  32'd0);
        chk("rst_err",       32'(b4.err_sync),  32'd0);
        chk("rst_in_ready",  32'(b4.in_ready),  32'd1);
        rst_n = 1'b1;
        idle(1);

        // Basic frame 1,0,1,1 -> 4'b1101
        q4.push_back(4'b1101);
        send4(1, 1); send4(0, 0); send4(0, 1);
        chk("basic_not_early", 32'(b4.out_valid), 32'd0);
        send4(0, 1);
        chk("basic_latency", 32'(b4.out_valid), 32'd1);
        idle(2);

        // Hunt from reset: stray samples dropped without error
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        e = errs4;
        q4.push_back(4'b0110);
        send4(0, 1); send4(0, 1);
        send4(1, 0); send4(0, 1); send4(0, 1); send4(0, 0);
        idle(2);
        chk("hunt_no_err", 32'(errs4), 32'(e));

        // Resync: sof in the middle of a frame
        q4.push_back(4'b1000);
        send4(1, 1); send4(0, 1);
        send4(1, 0);
        chk("resync_err", 32'(b4.err_sync), 32'd1);
        send4(0, 0);
        chk("resync_err_pulse", 32'(b4.err_sync), 32'd0);
        send4(0, 0); send4(0, 1);
        idle(2);

        // Backpressure: two frames while the consumer is stalled
        b4.out_ready = 1'b0;
        q4.push_back(4'b0001);
        q4.push_back(4'b1110);
        send4(1, 1); send4(0, 0); send4(0, 0); send4(0, 0);
        send4(1, 0); send4(0, 1); send4(0, 1);
        chk("bp_hold_valid", 32'(b4.out_valid), 32'd1);
        chk("bp_hold_data",  32'(b4.out_data),  32'h1);
        b4.in_valid = 1'b1; b4.in_sof = 1'b0; b4.in_data = 1'b1;
        @(negedge clk);
        chk("bp_stall", 32'(b4.in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_stall2", 32'(b4.in_ready), 32'd0);
        chk("bp_stable", 32'(b4.out_data), 32'h1);
        @(posedge clk); #1 b4.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'(b4.in_ready), 32'd1);
        @(posedge clk); #1 b4.in_valid = 1'b0;
        chk("bp_no_gap_valid", 32'(b4.out_valid), 32'd1);
        chk("bp_no_gap_data",  32'(b4.out_data),  32'he);
        idle(2);

        // Missing sof at lane 0 after a complete frame
        send4(0, 0);
        chk("nosof_err", 32'(b4.err_sync), 32'd1);
        q4.push_back(4'b0011);
        send4(1, 1); send4(0, 1); send4(0, 0); send4(0, 0);
        idle(2);

        // Reset while a frame is held and another is half-filled
        b4.out_ready = 1'b0;
        send4(1, 1); send4(0, 0); send4(0, 1); send4(0, 0);
        send4(1, 1); send4(0, 1);
        chk("pre_rst_valid", 32'(b4.out_valid), 32'd1);
        chk("pre_rst_data",  32'(b4.out_data),  32'h5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(b4.out_valid), 32'd0);
        chk("async_rst_data",  32'(b4.out_data),  32'd0);
        chk("async_rst_err",   32'(b4.err_sync),  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        b4.out_ready = 1'b1;
        send4(0, 1); send4(0, 1); send4(0, 1); send4(0, 1);
        idle(1);
        chk("post_rst_needs_sof", 32'(b4.out_valid), 32'd0);
        q4.push_back(4'b1000);
        send4(1, 0); send4(0, 0); send4(0, 0); send4(0, 1);
        idle(2);

        // Wide samples
        q8.push_back(32'h00FF3CA5);
        send8(1, 8'hA5); send8(0, 8'h3C); send8(0, 8'hFF); send8(0, 8'h00);
        chk("w8_latency", 32'(b8.out_valid), 32'd1);
        send8(0, 8'h11);
        chk("w8_nosof_err", 32'(b8.err_sync), 32'd1);
        q8.push_back(32'h04030201);
        send8(1, 8'h01); send8(0, 8'h02); send8(0, 8'h03); send8(0, 8'h04);
        idle(4);

        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("err4_total", 32'(errs4), 32'd2);
        chk("err8_total", 32'(errs8), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
